bus_transfer_ctrl: RTL and testbench

Sequencer for the shared 32-bit single-bus register bank. Register instances connect to the common bus. The block accepts one micro-op at a time: load constant, move, or swap. It drives one-hot register in/out enables and the constant-injection mux select, guaranteeing at most one bus driver per cycle. A swap uses a reserved temp register and takes three bus transfers.

---
 rtl/bus_transfer_ctrl_pkg.sv | 19 +
 rtl/bus_transfer_ctrl_if.sv | 31 +++
 rtl/reg_sel_decoder.sv | 19 +
 rtl/bus_transfer_ctrl.sv | 163 ++++++++++++++++
 tb/tb_bus_transfer_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_transfer_ctrl_pkg.sv
// rtl/bus_transfer_ctrl_pkg.sv - opcodes and FSM state encodings for the bus transfer sequencer
package bus_transfer_ctrl_pkg;

  // Micro-op encoding carried on cmd_op
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOADC = 2'b01,
    OP_MOVE  = 2'b10,
    OP_SWAP  = 2'b11
  } op_e;

  // Sequencer states; X1..X3 are the bus transfer slots
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_X1   = 3'd1;
  localparam logic [2:0] ST_X2   = 3'd2;
  localparam logic [2:0] ST_X3   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/bus_transfer_ctrl_if.sv
// rtl/bus_transfer_ctrl_if.sv - command handshake and register-bank enable bundle
interface bus_transfer_ctrl_if #(
  parameter int NUM_REGS = 4,
  parameter int WIDTH    = 32,
  parameter int IDX_W    = 2
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [IDX_W-1:0]    cmd_src;
  logic [IDX_W-1:0]    cmd_dst;
  logic [WIDTH-1:0]    cmd_const;
  logic [NUM_REGS-1:0] reg_in;
  logic [NUM_REGS-1:0] reg_out;
  logic                const_en;
  logic [WIDTH-1:0]    const_val;
  logic                done;
  logic                err;

  // Command issuer: drives micro-ops, observes bank enables and completion
  modport master (
    output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_const,
    input  cmd_ready, reg_in, reg_out, const_en, const_val, done, err
  );

  // Sequencer: accepts micro-ops, drives bank enables and completion
  modport slave (
    input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_const,
    output cmd_ready, reg_in, reg_out, const_en, const_val, done, err
  );
endinterface

// File: rtl/reg_sel_decoder.sv
// rtl/reg_sel_decoder.sv - register index to one-hot enable decoder
module reg_sel_decoder #(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = 2
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  // One bit at most; an index beyond the bank yields no enable at all
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = en && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// rtl/bus_transfer_ctrl.sv - single-bus register bank sequencer for load-constant, move and swap
module bus_transfer_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int WIDTH    = 32,
  parameter int IDX_W    = 2,
  parameter int TMP_IDX  = NUM_REGS - 1
) (
  input  logic             clk,
  input  logic             reset,
  bus_transfer_ctrl_if.slave bus
);
  import bus_transfer_ctrl_pkg::*;

  localparam logic [IDX_W-1:0] TMP = IDX_W'(TMP_IDX);

  logic [2:0]            state, state_n;
  logic                  swap_q;
  logic [IDX_W-1:0]      src_q, dst_q;
  logic                  in_en_n, out_en_n, const_en_n, err_n, load_const;
  logic [IDX_W-1:0]      in_idx_n, out_idx_n;
  logic [NUM_REGS-1:0]   reg_in_n, reg_out_n;
  logic [2**IDX_W-1:0]   idx_ok;
  logic                  src_ok, dst_ok;
  logic [WIDTH-1:0]      const_q;

  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.const_val = const_q;
  assign src_ok        = idx_ok[bus.cmd_src];
  assign dst_ok        = idx_ok[bus.cmd_dst];

  // Mask of encodable indices that actually exist in the bank
  always_comb begin
    idx_ok = '0;
    for (int i = 0; i < 2**IDX_W; i++) begin
      idx_ok[i] = (i < NUM_REGS);
    end
  end

  // Next state and next-cycle transfer selection; illegal and degenerate ops skip to DONE
  always_comb begin
    state_n    = state;
    in_en_n    = 1'b0;
    out_en_n   = 1'b0;
    in_idx_n   = '0;
    out_idx_n  = '0;
    const_en_n = 1'b0;
    err_n      = 1'b0;
    load_const = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_n = ST_DONE;
          case (bus.cmd_op)
            OP_NOP: ;
            OP_LOADC: begin
              if (!dst_ok) begin
                err_n = 1'b1;
              end else begin
                state_n    = ST_X1;
                in_en_n    = 1'b1;
                in_idx_n   = bus.cmd_dst;
                const_en_n = 1'b1;
                load_const = 1'b1;
              end
            end
            OP_MOVE: begin
              if (!src_ok || !dst_ok) begin
                err_n = 1'b1;
              end else if (bus.cmd_src != bus.cmd_dst) begin
                state_n   = ST_X1;
                out_en_n  = 1'b1;
                out_idx_n = bus.cmd_src;
                in_en_n   = 1'b1;
                in_idx_n  = bus.cmd_dst;
              end
            end
            default: begin
              if (!src_ok || !dst_ok || bus.cmd_src == TMP || bus.cmd_dst == TMP) begin
                err_n = 1'b1;
              end else if (bus.cmd_src != bus.cmd_dst) begin
                state_n   = ST_X1;
                out_en_n  = 1'b1;
                out_idx_n = bus.cmd_src;
                in_en_n   = 1'b1;
                in_idx_n  = TMP;
              end
            end
          endcase
        end
      end
      ST_X1: begin
        if (swap_q) begin
          state_n   = ST_X2;
          out_en_n  = 1'b1;
          out_idx_n = dst_q;
          in_en_n   = 1'b1;
          in_idx_n  = src_q;
        end else begin
          state_n = ST_DONE;
        end
      end
      ST_X2: begin
        state_n   = ST_X3;
        out_en_n  = 1'b1;
        out_idx_n = TMP;
        in_en_n   = 1'b1;
        in_idx_n  = dst_q;
      end
      ST_X3:   state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  reg_sel_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_in_dec (
    .idx    (in_idx_n),
    .en     (in_en_n),
    .onehot (reg_in_n)
  );

  reg_sel_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_out_dec (
    .idx    (out_idx_n),
    .en     (out_en_n),
    .onehot (reg_out_n)
  );

  // Capture operands at accept so the swap slots can replay them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      swap_q <= 1'b0;
      src_q  <= '0;
      dst_q  <= '0;
    end else if (state == ST_IDLE && bus.cmd_valid) begin
      swap_q <= (bus.cmd_op == OP_SWAP);
      src_q  <= bus.cmd_src;
      dst_q  <= bus.cmd_dst;
    end
  end

  // Registered state and bank-facing outputs; reset drops every enable at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      bus.reg_in   <= '0;
      bus.reg_out  <= '0;
      bus.const_en <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      const_q      <= '0;
    end else begin
      state        <= state_n;
      bus.reg_in   <= reg_in_n;
      bus.reg_out  <= reg_out_n;
      bus.const_en <= const_en_n;
      bus.done     <= (state_n == ST_DONE);
      bus.err      <= err_n;
      if (load_const) begin
        const_q <= bus.cmd_const;
      end
    end
  end

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// tb/tb_bus_transfer_ctrl.sv - randomized self-checking bench with a command-level bank model
module tb_bus_transfer_ctrl;

  localparam int NR  = 4;
  localparam int TMP = NR - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  bus_transfer_ctrl_if #(.NUM_REGS(NR), .WIDTH(32), .IDX_W(2)) bus ();

  bus_transfer_ctrl #(.NUM_REGS(NR), .WIDTH(32), .IDX_W(2), .TMP_IDX(TMP)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic [3:0] rin;
    logic [3:0] rout;
    logic       cen;
    logic       dn;
    logic       er;
  } rec_t;

  rec_t        q[$];
  rec_t        cur = '0;
  logic [31:0] cval = '0;
  logic [31:0] exp_bank[NR] = '{default: 32'd0};
  logic [31:0] bank_dut[NR] = '{default: 32'd0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] bitof(input int i);
    logic [3:0] one = 4'b0001;
    return one << i;
  endfunction

  function automatic rec_t xfer(input logic [3:0] rout, input logic [3:0] rin, input logic cen);
    rec_t r = '0;
    r.busy = 1'b1; r.rout = rout; r.rin = rin; r.cen = cen;
    return r;
  endfunction

  function automatic rec_t fin(input logic er);
    rec_t r = '0;
    r.busy = 1'b1; r.dn = 1'b1; r.er = er;
    return r;
  endfunction

  // Command-level semantics: per-cycle transfer list plus the resulting bank contents
  function automatic void plan(input logic [1:0] op, input int s, input int d, input logic [31:0] c);
    logic [31:0] a, b;
    case (op)
      2'b00: q.push_back(fin(1'b0));
      2'b01: begin
        q.push_back(xfer(4'b0000, bitof(d), 1'b1));
        q.push_back(fin(1'b0));
        exp_bank[d] = c;
        cval = c;
      end
      2'b10: begin
        if (s != d) begin
          q.push_back(xfer(bitof(s), bitof(d), 1'b0));
          exp_bank[d] = exp_bank[s];
        end
        q.push_back(fin(1'b0));
      end
      default: begin
        if (s == TMP || d == TMP) begin
          q.push_back(fin(1'b1));
        end else begin
          if (s != d) begin
            q.push_back(xfer(bitof(s), bitof(TMP), 1'b0));
            q.push_back(xfer(bitof(d), bitof(s), 1'b0));
            q.push_back(xfer(bitof(TMP), bitof(d), 1'b0));
            a = exp_bank[s];
            b = exp_bank[d];
            exp_bank[TMP] = a;
            exp_bank[s]   = b;
            exp_bank[d]   = a;
          end
          q.push_back(fin(1'b0));
        end
      end
    endcase
  endfunction

  // Model advance: cur is the expectation for the cycle following this edge
  always @(posedge clk) begin
    if (rst_n) begin
      if (q.size() > 0) begin
        cur = q.pop_front();
      end else if (!cur.busy && bus.cmd_valid) begin
        plan(bus.cmd_op, int'(bus.cmd_src), int'(bus.cmd_dst), bus.cmd_const);
        cur = q.pop_front();
      end else begin
        cur = '0;
      end
    end
  end

  always @(negedge rst_n) begin
    q.delete();
    cur  = '0;
    cval = '0;
  end

  // Register bank driven purely by the controller's enables
  always @(posedge clk) begin : bank_p
    logic [31:0] bv;
    bv = '0;
    for (int j = 0; j < NR; j++) if (bus.reg_out[j]) bv = bv | bank_dut[j];
    for (int i = 0; i < NR; i++) begin
      if (bus.reg_in[i]) bank_dut[i] <= bus.const_en ? bus.const_val : bv;
    end
  end

  // Per-cycle compare against the model plus bus-safety invariants
  always @(negedge clk) begin
    chk("reg_in", 64'(bus.reg_in), 64'(cur.rin));
    chk("reg_out", 64'(bus.reg_out), 64'(cur.rout));
    chk("const_en", 64'(bus.const_en), 64'(cur.cen));
    chk("done", 64'(bus.done), 64'(cur.dn));
    chk("err", 64'(bus.err), 64'(cur.er));
    chk("cmd_ready", 64'(bus.cmd_ready), 64'(!cur.busy));
    chk("const_val", 64'(bus.const_val), 64'(cval));
    chk("single_driver", 64'($countones(bus.reg_out) <= 1), 64'd1);
    chk("const_vs_drive", 64'(!(bus.const_en && bus.reg_out != 4'b0000)), 64'd1);
    chk("reg_in_onehot0", 64'($countones(bus.reg_in) <= 1), 64'd1);
    if (cur.dn) begin
      for (int i = 0; i < NR; i++) chk($sformatf("bank%0d", i), 64'(bank_dut[i]), 64'(exp_bank[i]));
    end
  end

  // Returns one time unit after the accepting edge
  task automatic issue(input logic [1:0] op, input logic [1:0] s, input logic [1:0] d,
                       input logic [31:0] c, input bit keep);
    int n = 0;
    @(negedge clk);
    bus.cmd_op = op; bus.cmd_src = s; bus.cmd_dst = d; bus.cmd_const = c;
    bus.cmd_valid = 1'b1;
    while (bus.cmd_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: cmd_ready got %b expected 1", bus.cmd_ready);
    end
    @(posedge clk);
    #1;
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_src = '0; bus.cmd_dst = '0; bus.cmd_const = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 64'(bus.cmd_ready), 64'd1);
    chk("rst_reg_in", 64'(bus.reg_in), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_const_val", 64'(bus.const_val), 64'd0);

    issue(2'b01, 2'd0, 2'd0, 32'd50, 1'b0);
    chk("loadc_reg_in", 64'(bus.reg_in), 64'b0001);
    chk("loadc_const_en", 64'(bus.const_en), 64'd1);
    chk("loadc_const_val", 64'(bus.const_val), 64'd50);
    @(posedge clk); #1;
    chk("loadc_done", 64'(bus.done), 64'd1);
    chk("loadc_err", 64'(bus.err), 64'd0);
    chk("loadc_bankA", 64'(bank_dut[0]), 64'd50);

    issue(2'b10, 2'd0, 2'd1, 32'd0, 1'b0);
    chk("move_reg_out", 64'(bus.reg_out), 64'b0001);
    chk("move_reg_in", 64'(bus.reg_in), 64'b0010);
    @(posedge clk); #1;
    chk("move_one_cycle", 64'(bus.reg_in), 64'd0);
    issue(2'b10, 2'd1, 2'd2, 32'd0, 1'b0);
    chk("move2_reg_out", 64'(bus.reg_out), 64'b0010);
    @(posedge clk); #1;
    chk("move2_bankC", 64'(bank_dut[2]), 64'd50);

    issue(2'b01, 2'd0, 2'd0, 32'd70, 1'b0);
    issue(2'b11, 2'd0, 2'd1, 32'd0, 1'b0);
    chk("swap1", 64'({bus.reg_out, bus.reg_in}), 64'b0001_1000);
    @(posedge clk); #1;
    chk("swap2", 64'({bus.reg_out, bus.reg_in}), 64'b0010_0001);
    @(posedge clk); #1;
    chk("swap3", 64'({bus.reg_out, bus.reg_in}), 64'b1000_0010);
    @(posedge clk); #1;
    chk("swap_done", 64'(bus.done), 64'd1);
    chk("swap_A", 64'(bank_dut[0]), 64'd50);
    chk("swap_B", 64'(bank_dut[1]), 64'd70);

    issue(2'b11, 2'd3, 2'd1, 32'd0, 1'b0);
    chk("swap_tmp_done_err", 64'({bus.done, bus.err, bus.reg_in, bus.reg_out}), 64'b11_0000_0000);
    issue(2'b10, 2'd2, 2'd2, 32'd0, 1'b0);
    chk("move_self_done_err", 64'({bus.done, bus.err, bus.reg_in, bus.reg_out}), 64'b10_0000_0000);

    issue(2'b01, 2'd2, 2'd2, 32'h1234, 1'b1);
    issue(2'b10, 2'd2, 2'd0, 32'd0, 1'b0);
    chk("b2b_move_out", 64'(bus.reg_out), 64'b0100);

    issue(2'b01, 2'd0, 2'd0, 32'd11, 1'b0);
    issue(2'b01, 2'd1, 2'd1, 32'd22, 1'b0);
    issue(2'b11, 2'd0, 2'd1, 32'd0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_enables", 64'({bus.reg_in, bus.reg_out, bus.const_en}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_bank[0] = 32'd11;
    exp_bank[1] = 32'd22;
    #1;
    chk("abort_tmp_kept", 64'(bank_dut[3]), 64'd11);
    chk("abort_A_kept", 64'(bank_dut[0]), 64'd11);
    chk("abort_ready", 64'(bus.cmd_ready), 64'd1);
    chk("abort_done", 64'(bus.done), 64'd0);
    issue(2'b01, 2'd2, 2'd2, 32'd99, 1'b0);
    @(posedge clk); #1;
    chk("post_abort_done", 64'(bus.done), 64'd1);
    chk("post_abort_bankC", 64'(bank_dut[2]), 64'd99);

    for (int k = 0; k < 200; k++) begin
      bit keep = 1'($urandom_range(0, 1));
      issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            32'($urandom), keep);
      if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    bus.cmd_valid = 1'b0;

    for (int n = 0; n < 64 && bus.cmd_ready !== 1'b1; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
